mux_scan_controller: RTL and testbench
======================================

# mux_scan_controller

Sequencer that sits around the team's 8-to-1 gate-level multiplexer. It drives the 3-bit select lines and samples the single-bit mux output, then assembles one bit per channel into an 8-bit word. A scan walks select 0→7, holds each select for a programmable dwell so the combinational mux path settles, and captures the output at the end of each dwell. It supports one-shot scans (start/done handshake) and continuous back-to-back scans.

## Interface
Parameters:
- SEL_W, default 3: select width; N = 2**SEL_W channels (default 8).
- DWELL, default 1: cycles each select value is held; legal range 1..255.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  begin a scan; sampled only in IDLE.
- cont  input  1  continuous mode; sampled at end of each scan.
- mux_out  input  1  output of the 8-to-1 mux being scanned.
- sel  output  SEL_W  select driven to the mux (registered).
- busy  output  1  high while a scan is in progress.
- sample_valid  output  1  one-cycle pulse per captured bit.
- sample_bit  output  1  bit captured on the current sample_valid pulse.
- sample_idx  output  SEL_W  channel index of sample_bit.
- word  output  N  last complete scan; word[k] = channel k.
- done  output  1  one-cycle pulse when word updates.

## Operation
- Reset values: sel=0, busy=0, sample_valid=0, sample_bit=0, sample_idx=0, word=0, done=0, state=IDLE, dwell counter=0, shadow register=0.
- States: IDLE and SCAN.
  - IDLE→SCAN when start=1.
  - SCAN→SCAN at the last channel when cont=1 (sel wraps to 0).
  - SCAN→IDLE at the last channel when cont=0.
- IDLE: sel=0, busy=0. Only start is examined.
- SCAN:
  - The dwell counter counts 0..DWELL-1 with sel held.
  - When the counter reaches DWELL-1, the next edge performs a capture:
    - mux_out is loaded into shadow[sel].
    - sample_valid=1, with sample_bit=mux_out and sample_idx=sel.
    - sel increments and the counter clears.
- Last-channel capture (sel=N-1):
  - word ← shadow with bit N-1 replaced by mux_out, loaded in one edge, so word never shows a partial scan.
  - done=1 for one cycle.
  - sel wraps to 0.
  - busy stays 1 if cont=1, else drops to 0.
- Boundary conditions:
  - start while busy is ignored.
  - cont dropped mid-scan: the current scan completes, then the block returns to IDLE.
  - cont raised in IDLE alone does nothing; start is required.
  - start and rst in the same cycle: rst wins.
  - rst mid-scan: partial data is discarded, word clears to 0, and no done pulse is generated.
  - DWELL=1: sel changes every cycle, and sample_valid stays high for N consecutive cycles.
  - sel wrap from N-1 to 0 is natural modulo-2^SEL_W arithmetic.

## Timing
- start is registered at edge E0; busy=1 and sel=0 are visible after E0.
- Capture of channel k occurs at edge E0+(k+1)·DWELL.
- done and the new word are visible after edge E0+N·DWELL (latency N·DWELL cycles; 8 cycles at the defaults).
- Continuous mode has no idle gap: scan j+1 channel 0 starts immediately after scan j's done edge, giving a period of exactly N·DWELL cycles.
- Earliest restart in one-shot mode: start asserted in the first cycle of IDLE after done is accepted at the next edge.
- The mux path (sel→mux_out) must settle within DWELL cycles minus setup.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package mux_scan_pkg:
  - state typedef (IDLE, SCAN);
  - default SEL_W and DWELL constants;
  - derived N.
- Sub-module mux_dwell_timer: 8-bit counter with clear and a terminal-count output at DWELL-1. It is instanced once and fires the capture enable.
- Top level contains the FSM, sel counter, shadow register, word register and sample outputs.

## Test plan
- Defaults, mux inputs i7..i0=1010_0110, start at cycle 0 → sel walks 0..7 on cycles 1..8; sample_valid is high for 8 cycles with idx 0..7; done pulses once; word=8'hA6 after cycle 8; busy=0 after.
- DWELL=3, same inputs → each sel value is held 3 cycles; captures occur at edges 3,6,…,24; word=8'hA6 exactly 24 cycles after start.
- cont=1 with inputs changed to 8'h5A between scans → done pulses every 8 cycles with no gap; words are 8'hA6 then 8'h5A. Dropping cont during scan 2 → scan 2 finishes, then IDLE.
- rst asserted at scan cycle 4 → next cycle all outputs are at reset values, word=0, no done. A new start yields a correct full scan.
- start pulsed at cycles 0, 3 and 8 (done cycle) → one scan only from cycle 0. The cycle-8 start is ignored because busy=1 until after that edge; start at cycle 9 launches the second scan.
- start and rst both high in one cycle → remains IDLE, busy=0, sel=0.

Source files
------------

// File: rtl/mux_scan_controller_pkg.sv
// mux_scan_pkg: state type and default geometry shared by the mux scan controller files
package mux_scan_pkg;
  typedef enum logic {IDLE, SCAN} state_t;
  localparam int SEL_W_DEF = 3;
  localparam int DWELL_DEF = 1;
  localparam int N_DEF = 2 ** SEL_W_DEF;
endpackage

// File: rtl/mux_scan_controller_if.sv
// mux_scan_controller_if: scan controller bus; master = requester/mux side, slave = controller
//   start, cont, mux_out        : master -> slave
//   sel, busy, sample_valid,
//   sample_bit, sample_idx,
//   word, done                  : slave -> master
interface mux_scan_controller_if import mux_scan_pkg::*; #(parameter int SEL_W = SEL_W_DEF);
  localparam int N = 2 ** SEL_W;
  logic start;
  logic cont;
  logic mux_out;
  logic [SEL_W-1:0] sel;
  logic busy;
  logic sample_valid;
  logic sample_bit;
  logic [SEL_W-1:0] sample_idx;
  logic [N-1:0] word;
  logic done;
  modport master (
    output start, cont, mux_out,
    input sel, busy, sample_valid, sample_bit, sample_idx, word, done
  );
  modport slave (
    input start, cont, mux_out,
    output sel, busy, sample_valid, sample_bit, sample_idx, word, done
  );
endinterface

// File: rtl/mux_scan_controller_timer.sv
// mux_dwell_timer: 8-bit dwell counter; tc marks the last cycle of each dwell
//   clk, rst : clock, sync active-high reset
//   clr      : hold counter at 0 (controller idle)
//   tc       : counter at DWELL-1 and not cleared; fires the capture
module mux_dwell_timer import mux_scan_pkg::*; #(
  parameter int DWELL = DWELL_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tc
);
  logic [7:0] cnt;
  assign tc = !clr && cnt == 8'(DWELL - 1);
  always_ff @(posedge clk) cnt <= (rst || clr || tc) ? 8'd0 : cnt + 8'd1;
endmodule

// File: rtl/mux_scan_controller.sv
// mux_scan_controller: walks an N-to-1 mux select, captures one bit per channel into a word
//   clk, rst : clock, sync active-high reset
//   bus      : slave side of mux_scan_controller_if (start/cont/mux_out in,
//              sel/busy/sample_valid/sample_bit/sample_idx/word/done out, all registered)
module mux_scan_controller import mux_scan_pkg::*; #(
  parameter int SEL_W = SEL_W_DEF,
  parameter int DWELL = DWELL_DEF
) (
  input logic clk,
  input logic rst,
  mux_scan_controller_if.slave bus
);
  localparam int N = 2 ** SEL_W;
  state_t state, state_n;
  logic cap, last;
  logic [N-1:0] shadow, word_n;
  mux_dwell_timer #(.DWELL(DWELL)) u_timer (.clk(clk), .rst(rst), .clr(state == IDLE), .tc(cap));
  assign last = cap && bus.sel == SEL_W'(N - 1);
  always_comb state_n = state == IDLE ? (bus.start ? SCAN : IDLE) : (last && !bus.cont ? IDLE : SCAN);
  // the final channel goes straight into word so it never shows a partial scan
  always_comb begin
    word_n = shadow;
    word_n[N-1] = bus.mux_out;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus.sel <= '0;
      bus.busy <= 1'b0;
      bus.sample_valid <= 1'b0;
      bus.sample_bit <= 1'b0;
      bus.sample_idx <= '0;
      bus.word <= '0;
      bus.done <= 1'b0;
      shadow <= '0;
    end else begin
      state <= state_n;
      bus.busy <= state_n == SCAN;
      bus.sample_valid <= cap;
      bus.done <= last;
      if (cap) begin
        bus.sel <= bus.sel + SEL_W'(1);
        bus.sample_bit <= bus.mux_out;
        bus.sample_idx <= bus.sel;
        shadow[bus.sel] <= bus.mux_out;
      end
      if (last) bus.word <= word_n;
    end
  end
endmodule

// File: tb/tb_mux_scan_controller.sv
// tb_mux_scan_controller: directed vector table for DWELL=1 plus a DWELL=3 timing sequence
module tb_mux_scan_controller;
  import mux_scan_pkg::*;
  typedef struct {
    logic rst, start, cont;
    logic [7:0] mux;
    logic busy;
    logic [2:0] sel;
    logic sv;
    logic [2:0] idx;
    logic b;
    logic done;
    logic [7:0] word;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] mux1 = 8'h00;
  logic [7:0] mux3 = 8'h00;
  int nvec = 0;
  int nerr = 0;
  vec_t tbl[$];
  always #5 clk = ~clk;
  mux_scan_controller_if #(.SEL_W(3)) b1 ();
  mux_scan_controller_if #(.SEL_W(3)) b3 ();
  assign b1.mux_out = mux1[b1.sel];
  assign b3.mux_out = mux3[b3.sel];
  mux_scan_controller #(.SEL_W(3), .DWELL(1)) d1 (.clk(clk), .rst(rst), .bus(b1));
  mux_scan_controller #(.SEL_W(3), .DWELL(3)) d3 (.clk(clk), .rst(rst), .bus(b3));
  function automatic vec_t mk(input int r, s, c, input logic [7:0] m, input int bz, sl, sv, ix, b, dn,
                              input logic [7:0] w);
    vec_t v;
    v.rst = r[0];
    v.start = s[0];
    v.cont = c[0];
    v.mux = m;
    v.busy = bz[0];
    v.sel = 3'(sl);
    v.sv = sv[0];
    v.idx = 3'(ix);
    v.b = b[0];
    v.done = dn[0];
    v.word = w;
    return v;
  endfunction
  // expected vectors for n captures of a scan of pattern m; cm/sm give cont/start per capture cycle
  task automatic add_scan(input logic [7:0] m, cm, sm, input int n, input logic [7:0] prev);
    for (int k = 0; k < n; k++)
      tbl.push_back(mk(0, int'(sm[k]), int'(cm[k]), m, int'(k < 7 || cm[7]), (k + 1) % 8, 1, k,
                       int'(m[k]), int'(k == 7), k == 7 ? m : prev));
  endtask
  task automatic chk(input string nm, input logic busy, input logic [2:0] sel, input logic sv,
                     input logic [2:0] idx, input logic b, input logic done, input logic [7:0] word,
                     input vec_t e);
    logic ok;
    nvec++;
    ok = busy === e.busy && sel === e.sel && sv === e.sv && done === e.done && word === e.word
         && (!e.sv || (idx === e.idx && b === e.b));
    if (!ok) begin
      nerr++;
      $display("FAIL %s: got busy=%b sel=%0d sv=%b idx=%0d bit=%b done=%b word=%h, want busy=%b sel=%0d sv=%b idx=%0d bit=%b done=%b word=%h",
               nm, busy, sel, sv, idx, b, done, word, e.busy, e.sel, e.sv, e.idx, e.b, e.done, e.word);
    end
  endtask
  initial begin
    b1.start = 1'b0;
    b1.cont = 1'b0;
    b3.start = 1'b0;
    b3.cont = 1'b0;
    tbl.push_back(mk(1, 0, 0, 8'hA6, 0, 0, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 1, 0, 8'hA6, 1, 0, 0, 0, 0, 0, 8'h00));
    add_scan(8'hA6, 8'h00, 8'h84, 8, 8'h00);
    tbl.push_back(mk(0, 1, 1, 8'hA6, 1, 0, 0, 0, 0, 0, 8'hA6));
    add_scan(8'hA6, 8'hFF, 8'h00, 8, 8'hA6);
    add_scan(8'h5A, 8'h07, 8'h00, 8, 8'hA6);
    tbl.push_back(mk(0, 0, 1, 8'h5A, 0, 0, 0, 0, 0, 0, 8'h5A));
    tbl.push_back(mk(0, 0, 1, 8'h5A, 0, 0, 0, 0, 0, 0, 8'h5A));
    tbl.push_back(mk(1, 1, 0, 8'h5A, 0, 0, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 8'h5A, 0, 0, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 1, 0, 8'hC3, 1, 0, 0, 0, 0, 0, 8'h00));
    add_scan(8'hC3, 8'h00, 8'h00, 4, 8'h00);
    tbl.push_back(mk(1, 0, 0, 8'hC3, 0, 0, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 8'hC3, 0, 0, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 1, 0, 8'h3C, 1, 0, 0, 0, 0, 0, 8'h00));
    add_scan(8'h3C, 8'h00, 8'h00, 8, 8'h00);
    tbl.push_back(mk(0, 0, 0, 8'h3C, 0, 0, 0, 0, 0, 0, 8'h3C));
    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst;
      b1.start = tbl[i].start;
      b1.cont = tbl[i].cont;
      mux1 = tbl[i].mux;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), b1.busy, b1.sel, b1.sample_valid, b1.sample_idx, b1.sample_bit,
          b1.done, b1.word, tbl[i]);
    end
    @(negedge clk);
    rst = 1'b1;
    b1.start = 1'b0;
    @(posedge clk);
    #1;
    chk("d3_reset", b3.busy, b3.sel, b3.sample_valid, b3.sample_idx, b3.sample_bit, b3.done, b3.word,
        mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00));
    @(negedge clk);
    rst = 1'b0;
    mux3 = 8'hA6;
    b3.start = 1'b1;
    @(posedge clk);
    #1;
    chk("d3_start", b3.busy, b3.sel, b3.sample_valid, b3.sample_idx, b3.sample_bit, b3.done, b3.word,
        mk(0, 1, 0, 8'hA6, 1, 0, 0, 0, 0, 0, 8'h00));
    @(negedge clk);
    b3.start = 1'b0;
    for (int t = 1; t <= 24; t++) begin
      @(posedge clk);
      #1;
      chk($sformatf("d3_t%0d", t), b3.busy, b3.sel, b3.sample_valid, b3.sample_idx, b3.sample_bit,
          b3.done, b3.word,
          mk(0, 0, 0, 8'hA6, int'(t < 24), (t / 3) % 8, int'(t % 3 == 0), t / 3 - 1,
             t % 3 == 0 ? int'(mux3[t / 3 - 1]) : 0, int'(t == 24), t == 24 ? 8'hA6 : 8'h00));
    end
    @(posedge clk);
    #1;
    chk("d3_idle", b3.busy, b3.sel, b3.sample_valid, b3.sample_idx, b3.sample_bit, b3.done, b3.word,
        mk(0, 0, 0, 8'hA6, 0, 0, 0, 0, 0, 0, 8'hA6));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
